// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helper for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial MSB-first CRC-8 step.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Serial CRC-8 accumulator: one bit per enabled cycle, synchronous clear.
module ccff_crc8_serial
    import ccff_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC8_INIT;
        end else if (clear_i) begin
            crc_q <= CRC8_INIT;
        end else if (enable_i) begin
            crc_q <= crc8_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes a byte stream into a configuration chain, then optionally
// recirculates the chain once and compares load/readback CRC-8.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 18,
    parameter bit          VERIFY_EN = 1'b1
) (
    input  logic       prog_clk,
    input  logic       pReset_n,
    input  logic       start,
    input  logic [7:0] bs_data,
    input  logic       bs_valid,
    output logic       bs_ready,
    output logic       config_enable,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       crc_err
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int unsigned BYTE_W = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BYTE_W-1:0] BYTES_ALL = BYTE_W'(NBYTES);

    state_e            state_q;
    logic [7:0]        hold_q;
    logic              hold_vld_q;
    logic [2:0]        idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] byte_cnt_q;
    logic              head_q;
    logic              cen_q;
    logic              done_q;
    logic              crc_err_q;

    logic       need_byte_c;
    logic       accept_c;
    logic       issue_c;
    logic       bit_c;
    logic       crc_clr_c;
    logic       vcrc_en_c;
    logic [7:0] load_crc;
    logic [7:0] vfy_crc;

    // An empty holding register is bypassed so an accepted byte's MSB shifts immediately.
    assign need_byte_c = (state_q == LOAD) && (byte_cnt_q != BYTES_ALL);
    assign bs_ready    = need_byte_c &&
                         (!hold_vld_q || ((idx_q == 3'd7) && (cnt_q != CNT_FULL)));
    assign accept_c    = bs_valid && bs_ready;
    assign issue_c     = (state_q == LOAD) && (cnt_q != CNT_FULL) && (hold_vld_q || accept_c);
    assign bit_c       = hold_vld_q ? hold_q[7] : bs_data[7];
    assign crc_clr_c   = (state_q == IDLE) && start;
    assign vcrc_en_c   = (state_q == VERIFY);

    ccff_crc8_serial u_load_crc (
        .clk_i    (prog_clk),
        .rst_ni   (pReset_n),
        .enable_i (issue_c),
        .clear_i  (crc_clr_c),
        .bit_i    (bit_c),
        .crc_o    (load_crc)
    );

    ccff_crc8_serial u_vfy_crc (
        .clk_i    (prog_clk),
        .rst_ni   (pReset_n),
        .enable_i (vcrc_en_c),
        .clear_i  (crc_clr_c),
        .bit_i    (ccff_tail),
        .crc_o    (vfy_crc)
    );

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q    <= IDLE;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            head_q     <= 1'b0;
            cen_q      <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cen_q <= 1'b0;
                    if (start) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        byte_cnt_q <= '0;
                        hold_vld_q <= 1'b0;
                        idx_q      <= 3'd0;
                        crc_err_q  <= 1'b0;
                    end
                end

                LOAD: begin
                    cen_q <= issue_c;
                    if (issue_c) begin
                        head_q <= bit_c;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                    if (accept_c) begin
                        byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                    end
                    if (hold_vld_q && issue_c) begin
                        if (idx_q == 3'd7) begin
                            hold_vld_q <= accept_c;
                            hold_q     <= bs_data;
                            idx_q      <= 3'd0;
                        end else begin
                            hold_q <= {hold_q[6:0], 1'b0};
                            idx_q  <= idx_q + 3'd1;
                        end
                    end else if (!hold_vld_q && accept_c) begin
                        hold_q     <= {bs_data[6:0], 1'b0};
                        hold_vld_q <= 1'b1;
                        idx_q      <= 3'd1;
                    end
                    // Last bit is on the chain input this cycle; leftover byte bits are dropped.
                    if (cnt_q == CNT_FULL) begin
                        hold_vld_q <= 1'b0;
                        head_q     <= 1'b0;
                        cnt_q      <= '0;
                        if (VERIFY_EN) begin
                            state_q <= VERIFY;
                            cen_q   <= 1'b1;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end

                VERIFY: begin
                    cen_q <= 1'b1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= FINISH;
                        cen_q     <= 1'b0;
                        done_q    <= 1'b1;
                        crc_err_q <= (load_crc != crc8_step(vfy_crc, ccff_tail));
                    end
                end

                FINISH: begin
                    cen_q   <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    cen_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Recirculation path: the chain's own output is fed straight back in.
    assign ccff_head     = (state_q == VERIFY) ? ccff_tail : head_q;
    assign config_enable = cen_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign crc_err       = crc_err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed table, hand sequences and random ops
// against a chain model plus expectations computed from the byte stream.
module tb_ccff_chain_loader;

    localparam int unsigned L     = 18;
    localparam int unsigned NB    = 3;
    localparam int unsigned FLIPK = 5;
    localparam logic [L-1:0] FMASK = L'(1) << FLIPK;

    typedef struct {
        logic [8*NB-1:0] data;
        int              hold_byte;
        int              hold_n;
        bit              flip;
        bit              restart;
        bit              nv;
        int              exp_lat;
        logic            exp_err;
        logic [L-1:0]    exp_bits;
    } vec_t;

    logic prog_clk = 1'b0;
    logic pReset_n;
    logic start;
    logic [7:0] bs_data;
    logic bs_valid;
    logic nv_sel;
    logic flip_arm;

    logic start_v, rdy_v, cen_v, head_v, tail_v, busy_v, done_v, err_v;
    logic start_nv, rdy_nv, cen_nv, head_nv, tail_nv, busy_nv, done_nv, err_nv;
    logic [L-1:0] chain_v  = '0;
    logic [L-1:0] chain_nv = '0;
    int shifts_v  = 0;
    int shifts_nv = 0;

    logic s_rdy, s_cen, s_head, s_busy, s_done, s_err;
    logic [L-1:0] s_chain;

    int n_vec = 0;
    int n_err = 0;

    always #5 prog_clk = ~prog_clk;

    assign start_v  = start & ~nv_sel;
    assign start_nv = start & nv_sel;

    ccff_chain_loader #(.CHAIN_LEN(L), .VERIFY_EN(1'b1)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start_v),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (rdy_v),
        .config_enable (cen_v),
        .ccff_head     (head_v),
        .ccff_tail     (tail_v),
        .busy          (busy_v),
        .done          (done_v),
        .crc_err       (err_v)
    );

    ccff_chain_loader #(.CHAIN_LEN(L), .VERIFY_EN(1'b0)) dut_nv (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start_nv),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (rdy_nv),
        .config_enable (cen_nv),
        .ccff_head     (head_nv),
        .ccff_tail     (tail_nv),
        .busy          (busy_nv),
        .done          (done_nv),
        .crc_err       (err_nv)
    );

    // Chain models: shift on every edge with config_enable; optional single-bit upset
    // applied together with the final load shift.
    assign tail_v  = chain_v[L-1];
    assign tail_nv = chain_nv[L-1];

    always @(posedge prog_clk) begin
        if (!busy_v) shifts_v <= 0;
        else if (cen_v) shifts_v <= shifts_v + 1;
        if (cen_v)
            chain_v <= {chain_v[L-2:0], head_v} ^ ((flip_arm && shifts_v == L - 1) ? FMASK : '0);
    end

    always @(posedge prog_clk) begin
        if (!busy_nv) shifts_nv <= 0;
        else if (cen_nv) shifts_nv <= shifts_nv + 1;
        if (cen_nv)
            chain_nv <= {chain_nv[L-2:0], head_nv} ^ ((flip_arm && shifts_nv == L - 1) ? FMASK : '0);
    end

    assign s_rdy   = nv_sel ? rdy_nv   : rdy_v;
    assign s_cen   = nv_sel ? cen_nv   : cen_v;
    assign s_head  = nv_sel ? head_nv  : head_v;
    assign s_busy  = nv_sel ? busy_nv  : busy_v;
    assign s_done  = nv_sel ? done_nv  : done_v;
    assign s_err   = nv_sel ? err_nv   : err_v;
    assign s_chain = nv_sel ? chain_nv : chain_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Starved-source cycles: withholding byte 0 delays everything one-for-one; for
    // later bytes the first ready cycle overlaps the previous byte's last shift.
    function automatic int stall_cycles(input int hold_byte, input int hold_n);
        if (hold_byte == 0) return hold_n;
        if (hold_byte > 0 && hold_byte < int'(NB) && hold_n > 0) return hold_n - 1;
        return 0;
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        int done_at, ndone, ncen, bub, bi, hold_left, exp_bub;
        logic err_done;
        logic [L-1:0] got;
        done_at = -1; ndone = 0; ncen = 0; bub = 0; bi = 0;
        hold_left = v.hold_n; err_done = 1'bx; got = '0;
        exp_bub = (v.hold_byte > 0) ? stall_cycles(v.hold_byte, v.hold_n) : 0;
        nv_sel = v.nv;
        flip_arm = v.flip;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk({tag, "/start_state"}, {29'd0, s_busy, s_rdy, s_err}, 32'h6);
        for (int k = 1; k <= 120; k++) begin
            if (k > 1) @(negedge prog_clk);
            if (ncen > 0 && ncen < int'(L) && !s_cen) bub++;
            if (s_cen) begin
                if (ncen < int'(L)) got = {got[L-2:0], s_head};
                ncen++;
            end
            if (s_done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    err_done = s_err;
                end
            end
            start = (v.restart && k == 6);
            bs_valid = 1'b0;
            if (bi < int'(NB) && s_rdy) begin
                if (bi == v.hold_byte && hold_left > 0) begin
                    hold_left--;
                end else begin
                    bs_valid = 1'b1;
                    bs_data = v.data[8*NB-1-8*bi -: 8];
                    bi++;
                end
            end
            if (done_at >= 0 && k >= done_at + 2) break;
        end
        start = 1'b0;
        bs_valid = 1'b0;
        chk({tag, "/done_latency"}, done_at, v.exp_lat);
        chk({tag, "/crc_err_at_done"}, {31'd0, err_done}, {31'd0, v.exp_err});
        chk({tag, "/load_bits"}, {14'd0, got}, {14'd0, v.exp_bits});
        chk({tag, "/shift_cycles"}, ncen, v.nv ? L : 2 * L);
        chk({tag, "/bubbles"}, bub, exp_bub);
        chk({tag, "/done_pulses"}, ndone, 1);
        chk({tag, "/chain"}, {14'd0, s_chain}, {14'd0, v.exp_bits ^ (v.flip ? FMASK : '0)});
        chk({tag, "/idle_after"}, {28'd0, s_busy, s_done, s_cen, s_rdy}, 32'h0);
        chk({tag, "/crc_err_held"}, {31'd0, s_err}, {31'd0, v.exp_err});
        flip_arm = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int nc, bi;

        tbl[0] = '{24'hA53CC0, -1, 0, 1'b0, 1'b0, 1'b0, 38, 1'b0, 18'h294F3};
        tbl[1] = '{24'hA53CC0,  1, 4, 1'b0, 1'b0, 1'b0, 41, 1'b0, 18'h294F3};
        tbl[2] = '{24'hA53CC0, -1, 0, 1'b1, 1'b0, 1'b0, 38, 1'b1, 18'h294F3};
        tbl[3] = '{24'hA53CC0, -1, 0, 1'b0, 1'b1, 1'b0, 38, 1'b0, 18'h294F3};
        tbl[4] = '{24'hA53CC0, -1, 0, 1'b0, 1'b0, 1'b1, 20, 1'b0, 18'h294F3};
        tbl[5] = '{24'h0FF03F,  0, 2, 1'b0, 1'b0, 1'b0, 40, 1'b0, 18'h03FC0};

        pReset_n = 1'b0;
        start = 1'b0;
        bs_valid = 1'b0;
        bs_data = 8'h00;
        nv_sel = 1'b0;
        flip_arm = 1'b0;
        #1;
        chk("reset/outputs", {26'd0, cen_v, head_v, rdy_v, busy_v, done_v, err_v}, 32'h0);
        chk("reset/outputs_nv", {26'd0, cen_nv, head_nv, rdy_nv, busy_nv, done_nv, err_nv}, 32'h0);
        repeat (2) @(negedge prog_clk);
        pReset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

        // Reset in the middle of a load, then a clean reload.
        nv_sel = 1'b0;
        nc = 0;
        bi = 0;
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int k = 0; k < 40 && nc < 7; k++) begin
            if (k > 0) @(negedge prog_clk);
            if (cen_v) nc++;
            bs_valid = rdy_v && (bi < 2);
            bs_data = (bi == 0) ? 8'h5A : 8'hFF;
            if (bs_valid) bi++;
        end
        chk("rst_mid/bits_before", nc, 7);
        #2;
        pReset_n = 1'b0;
        #1;
        chk("rst_mid/outputs", {26'd0, cen_v, head_v, rdy_v, busy_v, done_v, err_v}, 32'h0);
        bs_valid = 1'b0;
        @(negedge prog_clk);
        pReset_n = 1'b1;
        run_op("after_reset", tbl[0]);

        // Random ops; expectations come straight from the byte stream.
        for (int i = 0; i < 10; i++) begin
            rv.data      = 24'($urandom);
            rv.hold_byte = int'($urandom_range(0, 3));
            rv.hold_n    = int'($urandom_range(0, 4));
            rv.flip      = ($urandom_range(0, 3) == 0);
            rv.restart   = ($urandom_range(0, 4) == 0);
            rv.nv        = ($urandom_range(0, 3) == 0);
            rv.exp_bits  = rv.data[8*NB-1 -: L];
            rv.exp_err   = rv.flip && !rv.nv;
            rv.exp_lat   = 2 + (rv.nv ? int'(L) : 2 * int'(L)) + stall_cycles(rv.hold_byte, rv.hold_n);
            run_op($sformatf("rnd%0d", i), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencer that programs a configuration-chain segment (e.g. the 18-bit mode+SRAM chain of a fractured LUT4-arithmetic tile) from a byte-wide bitstream stream. It serializes bytes onto `ccff_head`, gates shifting with `config_enable`, and counts exactly `CHAIN_LEN` bits. Optionally it then recirculates the chain once (`ccff_tail` → `ccff_head`) and compares CRC-8 of the bits shifted in against CRC-8 of the bits shifted out. It sits between the bitstream source and the `ccff_head`/`ccff_tail` ends of a logic-block chain.

## Interface
Parameters:
- `CHAIN_LEN`, 18: number of chain flops to program (≥1).
- `VERIFY_EN`, 1: 1 = run the recirculate/CRC verify pass after load; 0 = skip it.

Ports:
- `prog_clk` in 1: the single clock; the chain also shifts on this clock.
- `pReset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to begin a load; sampled only in IDLE.
- `bs_data` in 8: bitstream byte, MSB shifted first.
- `bs_valid` in 1: `bs_data` valid.
- `bs_ready` out 1: byte accepted on a cycle where `bs_valid && bs_ready`.
- `config_enable` out 1: registered; chain shifts at each edge where it is 1.
- `ccff_head` out 1: serial bit into the chain.
- `ccff_tail` in 1: serial bit out of the chain.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at end of operation.
- `crc_err` out 1: verify mismatch; held until the next accepted `start`.

## Operation
- States: IDLE → LOAD → (VERIFY if `VERIFY_EN`) → FINISH → IDLE.
- IDLE: `config_enable`=0 and `bs_ready`=0. A `start` pulse moves to LOAD, clears the bit counter, both CRCs and `crc_err`. `start` in any other state is ignored.
- LOAD:
  - One-byte holding register plus a 3-bit bit index.
  - `bs_ready`=1 when the holding register is empty, or when it is on its last bit (index 7) and that bit is shifting this cycle. This gives zero-bubble streaming.
  - Each cycle a bit is available: registered `ccff_head`=bit and `config_enable`=1 for the following cycle. The bit counter increments and the load CRC is updated with that bit.
  - No bit available (underflow): `config_enable`=0. The chain holds and the counter holds.
  - After `CHAIN_LEN` bits, stop accepting bytes. Unused low bits of the final byte are discarded.
- VERIFY:
  - `ccff_head` = `ccff_tail` combinationally, so the chain contents are restored.
  - `config_enable`=1 for exactly `CHAIN_LEN` consecutive cycles.
  - Each such cycle updates the verify CRC with `ccff_tail`.
  - Exit compares the two CRCs and sets `crc_err` = (load CRC ≠ verify CRC).
- FINISH: `done`=1 for one cycle, then IDLE.
- CRC-8: polynomial 0x07, init 0x00, serial, MSB-first, no reflection or xor-out.
- Counter width: $clog2(CHAIN_LEN+1).
- Reset mid-operation: immediately return to IDLE with every output at its reset value. Chain contents are undefined; the caller must restart.

## Timing
- Reset values: `config_enable`=0, `ccff_head`=0, `bs_ready`=0, `busy`=0, `done`=0, `crc_err`=0.
- Cycle after `start` is sampled: `busy`=1 and `bs_ready`=1.
- Byte accepted at edge N: its MSB appears on `ccff_head` with `config_enable`=1 during cycle N+1.
- Sustained stream: `config_enable` high every cycle, i.e. 1 bit/cycle.
- Load of `CHAIN_LEN` bits with no stalls: `CHAIN_LEN` shift cycles after the first accept.
- VERIFY begins the cycle after the last load shift and lasts `CHAIN_LEN` cycles. `crc_err` is valid in the same cycle `done` pulses.
- Total operation with no stalls:
  - `VERIFY_EN`=1: 1 (accept) + 2·`CHAIN_LEN` + 1 (FINISH) cycles.
  - `VERIFY_EN`=0: 1 + `CHAIN_LEN` + 1 cycles.

## Structure
- Shared package `ccff_loader_pkg`: state enum (IDLE, LOAD, VERIFY, FINISH), `CRC8_POLY`=8'h07, `CRC8_INIT`=8'h00, function `crc8_step(crc, bit)`.
- Sub-module `ccff_crc8_serial` (enable, clear, bit, crc). Instantiated twice: load CRC and verify CRC.

## Test plan
- `CHAIN_LEN`=18; bytes 0xA5, 0x3C, 0xC0 streamed back-to-back → `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1 on 18 consecutive `config_enable` cycles. Chain model then holds that pattern, `crc_err`=0, `done` 38 cycles after `start`.
- Same data with `bs_valid` dropped for 3 cycles after the first byte → exactly 3 `config_enable`=0 cycles inserted. Same final chain pattern, `crc_err`=0.
- Bench chain model flips one stored bit before VERIFY → `crc_err`=1 at `done` and held. A new `start` clears it to 0.
- `start` pulsed while in LOAD → ignored. Bit count stays 18 and exactly one `done` pulse occurs.
- `pReset_n` asserted after 7 load bits → all outputs 0 asynchronously, `busy`=0. A fresh `start` and full load then succeed.
- `VERIFY_EN`=0 → `done` 20 cycles after `start`, no recirculation cycles, `crc_err`=0.
